// File: rtl/data_mem_arbiter.sv
// ============================================================================
// data_mem_arbiter : round-robin arbiter of per-thread LSU read/write channels
//                    onto one shared data-memory port.
// Optional macro DATA_ARB_PERF_COUNT_EN adds the grant_count port/counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module data_mem_arbiter #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,
  output logic                                     mem_read_valid,
  output logic [ADDR_BITS-1:0]                     mem_read_address,
  input  logic                                     mem_read_ready,
  input  logic [DATA_BITS-1:0]                     mem_read_data,
  output logic                                     mem_write_valid,
  output logic [ADDR_BITS-1:0]                     mem_write_address,
  output logic [DATA_BITS-1:0]                     mem_write_data,
  input  logic                                     mem_write_ready
`ifdef DATA_ARB_PERF_COUNT_EN
  ,output logic [15:0]                             grant_count
`endif
);

  localparam int c_IDX_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  localparam logic [2:0] c_IDLE        = 3'd0;
  localparam logic [2:0] c_READ_WAIT   = 3'd1;
  localparam logic [2:0] c_WRITE_WAIT  = 3'd2;
  localparam logic [2:0] c_READ_RELAY  = 3'd3;
  localparam logic [2:0] c_WRITE_RELAY = 3'd4;

  logic [2:0]         r_state;
  logic [c_IDX_W-1:0] r_rr;
  logic [c_IDX_W-1:0] r_sel;

  logic               w_found;
  logic               w_sel_read;
  logic [c_IDX_W-1:0] w_sel;
  logic               w_release;

  // base and k are both below NUM_CONSUMERS, so one subtraction wraps
  function automatic logic [c_IDX_W-1:0] f_wrap(input logic [c_IDX_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_CONSUMERS) s = s - NUM_CONSUMERS;
    return c_IDX_W'(s);
  endfunction

  always_comb begin
    w_found    = 1'b0;
    w_sel_read = 1'b0;
    w_sel      = '0;
    for (int k = 0; k < NUM_CONSUMERS; k++) begin
      if (!w_found && (consumer_read_valid[f_wrap(r_rr, k)] || consumer_write_valid[f_wrap(r_rr, k)])) begin
        w_found    = 1'b1;
        w_sel      = f_wrap(r_rr, k);
        w_sel_read = consumer_read_valid[f_wrap(r_rr, k)];
      end
    end
  end

  assign w_release = ((r_state == c_READ_RELAY)  && !consumer_read_valid[r_sel]) ||
                     ((r_state == c_WRITE_RELAY) && !consumer_write_valid[r_sel]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state              <= c_IDLE;
      r_rr                 <= '0;
      r_sel                <= '0;
      consumer_read_ready  <= '0;
      consumer_read_data   <= '0;
      consumer_write_ready <= '0;
      mem_read_valid       <= 1'b0;
      mem_read_address     <= '0;
      mem_write_valid      <= 1'b0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_found) begin
            r_sel <= w_sel;
            if (w_sel_read) begin
              mem_read_valid   <= 1'b1;
              mem_read_address <= consumer_read_address[w_sel];
              r_state          <= c_READ_WAIT;
            end else begin
              mem_write_valid   <= 1'b1;
              mem_write_address <= consumer_write_address[w_sel];
              mem_write_data    <= consumer_write_data[w_sel];
              r_state           <= c_WRITE_WAIT;
            end
          end
        end
        c_READ_WAIT: begin
          if (mem_read_ready) begin
            consumer_read_data[r_sel]  <= mem_read_data;
            consumer_read_ready[r_sel] <= 1'b1;
            mem_read_valid             <= 1'b0;
            r_state                    <= c_READ_RELAY;
          end
        end
        c_WRITE_WAIT: begin
          if (mem_write_ready) begin
            consumer_write_ready[r_sel] <= 1'b1;
            mem_write_valid             <= 1'b0;
            r_state                     <= c_WRITE_RELAY;
          end
        end
        c_READ_RELAY: begin
          if (w_release) begin
            consumer_read_ready[r_sel] <= 1'b0;
            r_rr                       <= f_wrap(r_sel, 1);
            r_state                    <= c_IDLE;
          end
        end
        c_WRITE_RELAY: begin
          if (w_release) begin
            consumer_write_ready[r_sel] <= 1'b0;
            r_rr                        <= f_wrap(r_sel, 1);
            r_state                     <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

`ifdef DATA_ARB_PERF_COUNT_EN
  logic [15:0] r_grant_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_grant_count <= '0;
    end else if (w_release && (r_grant_count != 16'hFFFF)) begin
      r_grant_count <= r_grant_count + 16'd1;
    end
  end

  assign grant_count = r_grant_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
// ============================================================================
// tb_data_mem_arbiter : directed self-checking bench for data_mem_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_data_mem_arbiter;

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0]      consumer_read_valid;
  logic [3:0][7:0] consumer_read_address;
  logic [3:0]      consumer_read_ready;
  logic [3:0][7:0] consumer_read_data;
  logic [3:0]      consumer_write_valid;
  logic [3:0][7:0] consumer_write_address;
  logic [3:0][7:0] consumer_write_data;
  logic [3:0]      consumer_write_ready;
  logic            mem_read_valid;
  logic [7:0]      mem_read_address;
  logic            mem_read_ready;
  logic [7:0]      mem_read_data;
  logic            mem_write_valid;
  logic [7:0]      mem_write_address;
  logic [7:0]      mem_write_data;
  logic            mem_write_ready;
`ifdef DATA_ARB_PERF_COUNT_EN
  logic [15:0]     grant_count;
`endif

  int tests = 0;
  int fails = 0;
  int both_hi = 0;
  int mem_lat = 1;
  logic [7:0] mem_store [256];
  logic [7:0] got_rd [4];
  int order [$];

  data_mem_arbiter #(.NUM_CONSUMERS(4), .ADDR_BITS(8), .DATA_BITS(8)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .consumer_read_valid    (consumer_read_valid),
    .consumer_read_address  (consumer_read_address),
    .consumer_read_ready    (consumer_read_ready),
    .consumer_read_data     (consumer_read_data),
    .consumer_write_valid   (consumer_write_valid),
    .consumer_write_address (consumer_write_address),
    .consumer_write_data    (consumer_write_data),
    .consumer_write_ready   (consumer_write_ready),
    .mem_read_valid         (mem_read_valid),
    .mem_read_address       (mem_read_address),
    .mem_read_ready         (mem_read_ready),
    .mem_read_data          (mem_read_data),
    .mem_write_valid        (mem_write_valid),
    .mem_write_address      (mem_write_address),
    .mem_write_data         (mem_write_data),
    .mem_write_ready        (mem_write_ready)
`ifdef DATA_ARB_PERF_COUNT_EN
    ,.grant_count           (grant_count)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mem_read_valid && mem_write_valid) both_hi++;

  // Memory responder: ready after mem_lat negedges of valid; read data = addr ^ 0xBB
  initial begin
    int rcnt;
    int wcnt;
    rcnt = 0;
    wcnt = 0;
    mem_read_ready  = 1'b0;
    mem_write_ready = 1'b0;
    mem_read_data   = '0;
    for (int a = 0; a < 256; a++) mem_store[a] = 8'(a) ^ 8'hBB;
    forever begin
      @(negedge clk);
      mem_read_ready  = 1'b0;
      mem_write_ready = 1'b0;
      if (mem_read_valid) begin
        rcnt++;
        if (rcnt >= mem_lat) begin
          mem_read_ready = 1'b1;
          mem_read_data  = mem_store[mem_read_address];
          rcnt = 0;
        end
      end else rcnt = 0;
      if (mem_write_valid) begin
        wcnt++;
        if (wcnt >= mem_lat) begin
          mem_write_ready = 1'b1;
          mem_store[mem_write_address] = mem_write_data;
          wcnt = 0;
        end
      end else wcnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drops each consumer's valid once its ready is seen; logs completion order
  task automatic serve(input int bound);
    int cyc = 0;
    while (((consumer_read_valid != 4'b0) || (consumer_write_valid != 4'b0)) && (cyc < bound)) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 4; i++) begin
        if (consumer_read_valid[i] && consumer_read_ready[i]) begin
          got_rd[i] = consumer_read_data[i];
          order.push_back(i);
          consumer_read_valid[i] = 1'b0;
        end
        if (consumer_write_valid[i] && consumer_write_ready[i]) begin
          order.push_back(16 + i);
          consumer_write_valid[i] = 1'b0;
        end
      end
    end
    chk("serve_in_budget", 32'(cyc < bound), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    reset                  = 1'b0;
    consumer_read_valid    = '0;
    consumer_read_address  = '0;
    consumer_write_valid   = '0;
    consumer_write_address = '0;
    consumer_write_data    = '0;
    for (int i = 0; i < 4; i++) got_rd[i] = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_mem_read_valid",  32'(mem_read_valid), 32'd0);
    chk("rst_mem_write_valid", 32'(mem_write_valid), 32'd0);
    chk("rst_mem_read_addr",   32'(mem_read_address), 32'd0);
    chk("rst_read_ready",      32'(consumer_read_ready), 32'd0);
    chk("rst_write_ready",     32'(consumer_write_ready), 32'd0);
    chk("rst_read_data",       32'(consumer_read_data), 32'd0);
`ifdef DATA_ARB_PERF_COUNT_EN
    chk("rst_grant_count",     32'(grant_count), 32'd0);
`endif
    reset = 1'b1;

    // Single read: consumer 2, addr 0x10 -> 0xAB
    @(negedge clk);
    consumer_read_valid[2]   = 1'b1;
    consumer_read_address[2] = 8'h10;
    @(negedge clk);
    chk("rd_mem_valid",   32'(mem_read_valid), 32'd1);
    chk("rd_mem_addr",    32'(mem_read_address), 32'h10);
    chk("rd_no_wr_valid", 32'(mem_write_valid), 32'd0);
    chk("rd_ready_early", 32'(consumer_read_ready), 32'd0);
    @(negedge clk);
    chk("rd_ready",       32'(consumer_read_ready), 32'b0100);
    chk("rd_data",        32'(consumer_read_data[2]), 32'hAB);
    chk("rd_valid_drop",  32'(mem_read_valid), 32'd0);
    consumer_read_valid[2] = 1'b0;
    @(negedge clk);
    chk("rd_ready_clr",   32'(consumer_read_ready), 32'd0);
    chk("rd_data_hold",   32'(consumer_read_data[2]), 32'hAB);

    // Single write: consumer 0 writes 0x5C to 0x20
    consumer_write_valid[0]   = 1'b1;
    consumer_write_address[0] = 8'h20;
    consumer_write_data[0]    = 8'h5C;
    @(negedge clk);
    chk("wr_mem_valid",   32'(mem_write_valid), 32'd1);
    chk("wr_mem_addr",    32'(mem_write_address), 32'h20);
    chk("wr_mem_data",    32'(mem_write_data), 32'h5C);
    chk("wr_no_rd_valid", 32'(mem_read_valid), 32'd0);
    @(negedge clk);
    chk("wr_ready",       32'(consumer_write_ready), 32'b0001);
    chk("wr_stored",      32'(mem_store[8'h20]), 32'h5C);
    consumer_write_valid[0] = 1'b0;
    @(negedge clk);
    chk("wr_ready_clr",   32'(consumer_write_ready), 32'd0);

    // Consumer 1 read moves the pointer to 2
    consumer_read_valid[1]   = 1'b1;
    consumer_read_address[1] = 8'h01;
    serve(20);
    chk("c1_rd_data", 32'(got_rd[1]), 32'hBA);

    // Mixed: consumer 1 write vs consumer 3 read with pointer at 2
    order.delete();
    consumer_write_valid[1]   = 1'b1;
    consumer_write_address[1] = 8'h21;
    consumer_write_data[1]    = 8'h77;
    consumer_read_valid[3]    = 1'b1;
    consumer_read_address[3]  = 8'h31;
    @(negedge clk);
    chk("mix_first_rd",   32'(mem_read_valid), 32'd1);
    chk("mix_first_addr", 32'(mem_read_address), 32'h31);
    serve(40);
    chk("mix_count",  32'(order.size()), 32'd2);
    chk("mix_order0", 32'(order[0]), 32'd3);
    chk("mix_order1", 32'(order[1]), 32'd17);
    chk("mix_rd3",    32'(got_rd[3]), 32'h8A);
    chk("mix_wr1",    32'(mem_store[8'h21]), 32'h77);

    // Reset during READ_WAIT
    mem_lat = 20;
    consumer_read_valid[1]   = 1'b1;
    consumer_read_address[1] = 8'h44;
    @(negedge clk);
    @(negedge clk);
    chk("rw_in_wait", 32'(mem_read_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rw_async_valid", 32'(mem_read_valid), 32'd0);
    chk("rw_async_ready", 32'(consumer_read_ready), 32'd0);
    consumer_read_valid[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset   = 1'b1;
    mem_lat = 1;
    consumer_read_valid[1]   = 1'b1;
    consumer_read_address[1] = 8'h33;
    serve(20);
    chk("rw_after_data", 32'(got_rd[1]), 32'h88);

    // Consumer drops valid mid-wait: ready still pulses for one cycle
    mem_lat = 3;
    consumer_read_valid[2]   = 1'b1;
    consumer_read_address[2] = 8'h05;
    @(negedge clk);
    chk("viol_granted", 32'(mem_read_valid), 32'd1);
    consumer_read_valid[2] = 1'b0;
    cyc = 0;
    while (!consumer_read_ready[2] && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk("viol_ready",  32'(consumer_read_ready), 32'b0100);
    chk("viol_data",   32'(consumer_read_data[2]), 32'hBE);
    @(negedge clk);
    chk("viol_pulse1", 32'(consumer_read_ready), 32'd0);

    // Contention from reset: all four read, memory latency 2
    reset = 1'b0;
    @(negedge clk);
    reset   = 1'b1;
    mem_lat = 2;
    order.delete();
    for (int i = 0; i < 4; i++) begin
      consumer_read_address[i] = 8'h40 + 8'(i);
      got_rd[i] = '0;
    end
    consumer_read_valid = 4'b1111;
    serve(100);
    chk("cont_count", 32'(order.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("cont_order", 32'(order[i]), 32'(i));
      chk("cont_data",  32'(got_rd[i]), 32'((8'h40 + 8'(i)) ^ 8'hBB));
    end

    // Fifth transaction since reset
    mem_lat = 1;
    consumer_write_valid[0]   = 1'b1;
    consumer_write_address[0] = 8'h60;
    consumer_write_data[0]    = 8'h11;
    serve(20);
    chk("fifth_wr", 32'(mem_store[8'h60]), 32'h11);
`ifdef DATA_ARB_PERF_COUNT_EN
    chk("grant_count_5", 32'(grant_count), 32'd5);
`endif

    chk("never_both_valid", 32'(both_hi), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
